// File: rtl/imem_ctrl_pkg.sv
// Purpose: shared state encoding and constants for the instruction-memory load controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // addi x0, x0, 0 -- returned whenever the core must not see real memory data
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int BYTE_LANES = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Purpose: packs a byte stream into little-endian 32-bit words; flush emits a zero-padded partial word.
// Latency: word_vld one cycle after the byte that completes a word (or after flush with a partial word).
// Backpressure: none, accepts a byte every cycle byte_vld is high.
//
// Ports: clk/rst (sync, active-high); clr drops the partial word (a byte in the same cycle
// starts the new word); byte_vld/byte_dat input stream; flush emits the partial word if any;
// word_vld/word_dat registered output word; bcnt = bytes currently held.
module imem_byte_packer
    import imem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    input  logic        flush,
    output logic        word_vld,
    output logic [31:0] word_dat,
    output logic [1:0]  bcnt
);

    logic [31:0] pack_q, pack_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        word_vld_q, word_vld_d;
    logic [31:0] base_pack, merged;
    logic [1:0]  base_cnt;

    always_comb begin
        // A clear restarts from an empty word but still takes a same-cycle byte.
        base_pack  = clr ? 32'd0 : pack_q;
        base_cnt   = clr ? 2'd0  : bcnt_q;
        merged     = base_pack;
        if (byte_vld) begin
            merged[{base_cnt, 3'b000} +: 8] = byte_dat;
        end
        pack_d     = merged;
        bcnt_d     = base_cnt + 2'(byte_vld);
        word_d     = word_q;
        word_vld_d = 1'b0;
        if (byte_vld && base_cnt == 2'(BYTE_LANES - 1)) begin
            word_d     = merged;
            word_vld_d = 1'b1;
            pack_d     = 32'd0;
            bcnt_d     = 2'd0;
        end else if (flush && !clr && !byte_vld && bcnt_q != 2'd0) begin
            // Unfilled upper lanes are already zero in the pack register.
            word_d     = pack_q;
            word_vld_d = 1'b1;
            pack_d     = 32'd0;
            bcnt_d     = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q     <= 32'd0;
            word_q     <= 32'd0;
            bcnt_q     <= 2'd0;
            word_vld_q <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign word_vld = word_vld_q;
    assign word_dat = word_q;
    assign bcnt     = bcnt_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Purpose: shares the instruction memory port between core fetch (RUN) and a byte-serial loader.
// Latency: write one cycle after the 4th byte; fetch path fully combinational pc_out -> inst.
// Backpressure: ld_ready high for the whole LOAD state, one byte per cycle with no bubbles.
//
// Ports: clk/rst (sync, active-high); pc_out/inst/stall/misalign core side;
// ld_start/ld_valid/ld_byte/ld_ready/ld_done/ld_err loader side;
// mem_addr/mem_rdata/mem_we/mem_wdata memory side (combinational read).
// Optional: IMEM_LOAD_CHECKSUM_EN adds ld_csum (running byte sum) and ld_csum_exp (checked at ld_done).
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int PC_WIDTH_LENGTH   = 32,
    parameter int INST_WIDTH_LENGTH = 32,
    parameter int ADDR_WIDTH        = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PC_WIDTH_LENGTH-1:0]   pc_out,
    output logic [INST_WIDTH_LENGTH-1:0] inst,
    output logic                         stall,
    output logic                         misalign,
    input  logic                         ld_start,
    input  logic                         ld_valid,
    input  logic [7:0]                   ld_byte,
    output logic                         ld_ready,
    input  logic                         ld_done,
    output logic                         ld_err,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [7:0]                   ld_csum,
    input  logic [7:0]                   ld_csum_exp,
`endif
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [INST_WIDTH_LENGTH-1:0] mem_rdata,
    output logic                         mem_we,
    output logic [INST_WIDTH_LENGTH-1:0] mem_wdata
);

    state_t                state_q, state_d;
    logic                  stall_q, stall_d;
    logic                  ld_ready_q, ld_ready_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  ld_err_q, ld_err_d;
    logic                  fl_wr_q, fl_wr_d;   // partial-word flush write already requested
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  csum_bad_q, csum_bad_d;
`endif

    logic        accept;
    logic        pk_flush;
    logic        pk_vld;
    logic [31:0] pk_word;
    logic [1:0]  pk_bcnt;
    logic        run;
    logic        unused_pc_hi;

    assign accept   = ld_valid & ld_ready_q;
    assign pk_flush = (state_q == ST_FLUSH) && !fl_wr_q;

    imem_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (ld_start),
        .byte_vld (accept),
        .byte_dat (ld_byte),
        .flush    (pk_flush),
        .word_vld (pk_vld),
        .word_dat (pk_word),
        .bcnt     (pk_bcnt)
    );

    // Once the image has overrun the memory, later words are dropped.
    assign mem_we    = pk_vld & ~ld_err_q;
    assign mem_wdata = pk_word;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        ld_err_d = ld_err_q;
        fl_wr_d  = fl_wr_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_d     = accept ? csum_q + ld_byte : csum_q;
        csum_bad_d = csum_bad_q;
`endif
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (&wr_ptr_q) begin
                ld_err_d = 1'b1;
            end
        end
        case (state_q)
            ST_BOOT: begin
                if (ld_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (ld_done) begin
                    state_d = ST_FLUSH;
                    fl_wr_d = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    // Compare against the sum including a byte accepted with ld_done.
                    csum_bad_d = (csum_d != ld_csum_exp);
`endif
                end
            end
            ST_FLUSH: begin
                if (!fl_wr_q && pk_bcnt != 2'd0) begin
                    // Stay one more cycle so the partial word is written before RUN.
                    fl_wr_d = 1'b1;
                end else begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    if (csum_bad_q) begin
                        state_d  = ST_BOOT;
                        ld_err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            default: ;
        endcase
        // A new session overrides everything from any state.
        if (ld_start) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            ld_err_d = 1'b0;
            fl_wr_d  = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_d     = accept ? ld_byte : 8'd0;
            csum_bad_d = 1'b0;
`endif
        end
    end

    assign stall_d    = (state_d != ST_RUN);
    assign ld_ready_d = (state_d == ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            stall_q    <= 1'b1;
            ld_ready_q <= 1'b0;
            wr_ptr_q   <= '0;
            ld_err_q   <= 1'b0;
            fl_wr_q    <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= 8'd0;
            csum_bad_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            ld_ready_q <= ld_ready_d;
            wr_ptr_q   <= wr_ptr_d;
            ld_err_q   <= ld_err_d;
            fl_wr_q    <= fl_wr_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= csum_d;
            csum_bad_q <= csum_bad_d;
`endif
        end
    end

    // Fetch path: PC bits above the memory depth are ignored.
    assign run          = (state_q == ST_RUN);
    assign unused_pc_hi = ^pc_out[PC_WIDTH_LENGTH-1:ADDR_WIDTH+2];
    assign misalign     = run && (pc_out[1:0] != 2'b00);
    assign mem_addr     = run ? pc_out[ADDR_WIDTH+1:2] : wr_ptr_q;
    assign inst         = (run && !misalign) ? mem_rdata : NOP_INST;
    assign stall        = stall_q;
    assign ld_ready     = ld_ready_q;
    assign ld_err       = ld_err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    assign ld_csum      = csum_q;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    localparam int AW = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   pc_out = 32'd0;
    logic [31:0]   inst;
    logic          stall, misalign;
    logic          ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
    logic [7:0]    ld_byte = 8'd0;
    logic          ld_ready, ld_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata, mem_wdata;
    logic          mem_we;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]    ld_csum;
    logic [7:0]    ld_csum_exp = 8'd0;
`endif

    always #5 clk = ~clk;

    imem_load_ctrl #(
        .PC_WIDTH_LENGTH   (32),
        .INST_WIDTH_LENGTH (32),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_out      (pc_out),
        .inst        (inst),
        .stall       (stall),
        .misalign    (misalign),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .ld_err      (ld_err),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .ld_csum     (ld_csum),
        .ld_csum_exp (ld_csum_exp),
`endif
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata)
    );

    // Memory model with combinational read
    logic [31:0] mem [4];
    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 32'hA5A5_0000 | i;
    end
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   dat;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.dat  = d;
        exp_q.push_back(e);
    endfunction

    // Write monitor: every mem_we must match the next expected write
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.dat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic pulse_done();
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (stall !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk(name, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        // Reset state
        chk("rst_stall",    32'(stall),    32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_wdata",    mem_wdata,     32'd0);
        chk("rst_ld_err",   32'(ld_err),   32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_inst",     inst,          NOP);
        rst = 1'b0;
        step();

        // Eight bytes back-to-back -> two words
        pulse_start();
        chk("load_stall", 32'(stall),    32'd1);
        chk("load_ready", 32'(ld_ready), 32'd1);
        push_wr(2'd0, 32'h0403_0201);
        push_wr(2'd1, 32'h0807_0605);
        for (int i = 1; i <= 8; i++) begin
            put_byte(8'(i));
            chk("stream_stall", 32'(stall),    32'd1);
            chk("stream_ready", 32'(ld_ready), 32'd1);
        end
        step();
        step();

        // Restart, five bytes, partial flush
        pulse_start();
        push_wr(2'd0, 32'hDDCC_BBAA);
        push_wr(2'd1, 32'h0000_00EE);
        put_byte(8'hAA);
        put_byte(8'hBB);
        put_byte(8'hCC);
        put_byte(8'hDD);
        put_byte(8'hEE);
        pulse_done();
        chk("flush_stall", 32'(stall), 32'd1);
        step();
        chk("flush_we",    32'(mem_we), 32'd1);
        chk("flush_stall2", 32'(stall), 32'd1);
        step();
        chk("run_stall", 32'(stall),    32'd0);
        chk("run_ready", 32'(ld_ready), 32'd0);

        // Fetch path
        pc_out = 32'h4; #1;
        chk("pc4_addr", 32'(mem_addr), 32'd1);
        chk("pc4_inst", inst,          32'h0000_00EE);
        chk("pc4_mis",  32'(misalign), 32'd0);
        pc_out = 32'h6; #1;
        chk("pc6_inst", inst,          NOP);
        chk("pc6_mis",  32'(misalign), 32'd1);
        pc_out = 32'h0; #1;
        chk("pc0_inst", inst,          32'hDDCC_BBAA);
        pc_out = 32'h8; #1;
        chk("pc8_addr", 32'(mem_addr), 32'd2);
        chk("pc8_inst", inst,          32'hA5A5_0002);
        step();

        // Reload from RUN: pointer restarts at 0
        pulse_start();
        chk("reload_stall", 32'(stall),    32'd1);
        chk("reload_mis",   32'(misalign), 32'd0);
        push_wr(2'd0, 32'h1122_3344);
        put_byte(8'h44);
        put_byte(8'h33);
        put_byte(8'h22);
        put_byte(8'h11);
        pulse_done();
        wait_run("reload_run");

        // Reset in the middle of a load: no write
        pulse_start();
        put_byte(8'h5A);
        put_byte(8'h6B);
        rst = 1'b1;
        step();
        chk("mid_rst_stall", 32'(stall),    32'd1);
        chk("mid_rst_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_we",    32'(mem_we),   32'd0);
        rst = 1'b0;
        step();
        pulse_done();
        wait_run("boot_done_run");
        pc_out = 32'h0; #1;
        chk("preload_inst", inst, 32'h1122_3344);
        step();

        // Overrun of a 4-word memory
        pulse_start();
        push_wr(2'd0, 32'h0302_0100);
        push_wr(2'd1, 32'h0706_0504);
        push_wr(2'd2, 32'h0B0A_0908);
        push_wr(2'd3, 32'h0F0E_0D0C);
        for (int i = 0; i < 20; i++) begin
            put_byte(8'(i));
            if (i == 14) chk("wrap_err_early", 32'(ld_err), 32'd0);
        end
        chk("wrap_no_we", 32'(mem_we), 32'd0);
        chk("wrap_err",   32'(ld_err), 32'd1);
        step();
        pulse_done();
        wait_run("wrap_run");
        chk("wrap_err_sticky", 32'(ld_err), 32'd1);
        pulse_start();
        chk("err_clear", 32'(ld_err), 32'd0);
        pulse_done();
        wait_run("empty_run");

`ifdef IMEM_LOAD_CHECKSUM_EN
        // Checksum mismatch keeps the core stalled
        pulse_start();
        chk("csum_clear", 32'(ld_csum), 32'd0);
        push_wr(2'd0, 32'h0000_02FF);
        put_byte(8'hFF);
        put_byte(8'h02);
        chk("csum_val", 32'(ld_csum), 32'h01);
        ld_csum_exp = 8'h02;
        pulse_done();
        repeat (4) step();
        chk("csum_err",   32'(ld_err), 32'd1);
        chk("csum_stall", 32'(stall),  32'd1);
`endif

        step();
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the instruction memory port and shares it between two requesters: the core fetch path and a byte-serial program loader (boot/UART).
- While loading, the controller stalls the core, packs incoming bytes into little-endian 32-bit words and writes them sequentially from word 0.
- In RUN it passes the fetch PC through to the memory and returns the instruction, trapping misaligned PCs.

Parameters:
- PC_WIDTH_LENGTH, 32, fetch PC width
- INST_WIDTH_LENGTH, 32, instruction/word width (fixed at 32 for byte packing)
- ADDR_WIDTH, 18, memory word-address width (depth = 1<<ADDR_WIDTH)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_out  in  PC_WIDTH_LENGTH  core fetch address (byte address)
- inst  out  INST_WIDTH_LENGTH  instruction to core
- stall  out  1  core must hold PC while high
- misalign  out  1  pc_out[1:0]!=0 during RUN
- ld_start  in  1  begin load session (single-cycle pulse)
- ld_valid  in  1  ld_byte is valid
- ld_byte  in  8  program byte
- ld_ready  out  1  controller accepts byte this cycle
- ld_done  in  1  end of image (pulse)
- ld_err  out  1  sticky: image exceeded memory depth
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_rdata  in  INST_WIDTH_LENGTH  memory read data (combinational read)
- mem_we  out  1  write strobe, one cycle per word
- mem_wdata  out  INST_WIDTH_LENGTH  write data

Behaviour:
- States: BOOT, LOAD, FLUSH, RUN.
- Reset values: state=BOOT, stall=1, ld_ready=0, mem_we=0, mem_wdata=0, ld_err=0, write pointer wr_ptr=0, byte count bcnt=0, pack register=0.
- BOOT:
  - stall=1, inst=0x00000013 (NOP).
  - ld_start -> LOAD.
  - ld_done without a load -> RUN, with memory contents untouched (preloaded image).
- LOAD:
  - stall=1, ld_ready=1, mem_addr=wr_ptr.
  - On ld_valid&ld_ready, ld_byte goes into pack[8*bcnt+:8], then bcnt++.
  - On the accept where bcnt==3, the next cycle drives mem_we=1 with the full word at wr_ptr; wr_ptr++ and bcnt=0. Byte-accept-to-write latency is 1 cycle, so sustained throughput is one byte per cycle with no bubbles.
  - ld_ready stays high during the write cycle. mem_addr during the write cycle is the write address; the pointer increments after the write.
- FLUSH (entered on ld_done):
  - If bcnt!=0, one write of the partial word with its upper bytes zero, then -> RUN.
  - If bcnt==0, -> RUN immediately (no write).
  - ld_done and ld_valid in the same cycle: the byte is accepted first, then the flush happens.
- Wrap-around: when a write occurs at wr_ptr=(1<<ADDR_WIDTH)-1, the pointer wraps to 0, ld_err sets and stays set. Further writes are suppressed (mem_we=0) until the next ld_start.
- RUN:
  - stall=0, ld_ready=0, mem_addr=pc_out[ADDR_WIDTH+1:2] (combinational).
  - If pc_out[1:0]==0: inst=mem_rdata, misalign=0.
  - Otherwise: inst=NOP, misalign=1 (combinational, no state change).
  - ld_start in RUN -> LOAD (reload): stall asserts the cycle after ld_start; wr_ptr, bcnt and ld_err clear.
- ld_start during LOAD restarts the session: wr_ptr=0, bcnt=0, the partial word is discarded and ld_err is cleared.
- Reset mid-load: returns to BOOT; any partial word is lost and no write is issued.
- misalign=0 in all states except RUN.
- Write ports are never driven in RUN, so the core never reads a word on the cycle it is written.

Optional Feature:
- IMEM_LOAD_CHECKSUM_EN
- Defined:
  - Adds output ld_csum[7:0], the modulo-256 sum of all bytes accepted in the current session. It clears on ld_start and on rst, and holds after RUN.
  - Adds input ld_csum_exp[7:0], sampled on ld_done. A mismatch keeps the FSM in BOOT after FLUSH (stall stays high) and sets ld_err.
- Not defined: neither port exists and ld_done always proceeds to RUN.

Decomposition:
- Package imem_ctrl_pkg holds:
  - the state encoding (BOOT=2'd0, LOAD=2'd1, FLUSH=2'd2, RUN=2'd3);
  - the NOP constant 32'h00000013;
  - the byte-lane count 4.
- One sub-module, imem_byte_packer: bytes in, word plus word_valid out, with flush and clear inputs. The FSM, arbitration mux and pointer stay in imem_load_ctrl.

Test Plan:
- Reset, then ld_start, then 8 bytes 01..08 streamed back-to-back -> two writes (mem_we one cycle each): addr0=0x04030201, addr1=0x08070605. stall=1 throughout.
- Load 5 bytes AA BB CC DD EE, then ld_done -> addr0=0xDDCCBBAA, then a flush write addr1=0x000000EE. Next cycle state=RUN, stall=0.
- RUN with pc_out=0x00000004 -> mem_addr=1, inst=mem_rdata. pc_out=0x00000006 -> inst=0x00000013, misalign=1.
- ADDR_WIDTH=2 build, load 20 bytes -> 4 writes at addrs 0..3, ld_err=1 after the 4th, no further mem_we.
- rst asserted after 2 bytes of a load -> no write; state=BOOT, stall=1, ld_ready=0 next cycle. ld_start in RUN -> stall=1 next cycle and wr_ptr restarts at 0.
- With IMEM_LOAD_CHECKSUM_EN: bytes 0xFF,0x02 -> ld_csum=0x01. ld_csum_exp=0x02 at ld_done -> ld_err=1, stall stays 1.
